// File: rtl/bias_pingpong_buffer.sv
// Ping-pong bias store: serial valid/ready load into one bank while the PE array reads the other.
// Optional: define BIAS_OVERFLOW_DET_EN to add a sticky o_overflow flag for words dropped while both banks are full.
module bias_pingpong_buffer #(
    parameter int BW   = 16,
    parameter int SIZE = 10,
    localparam int CNT_W = (SIZE > 1) ? $clog2(SIZE) : 1
) (
    input  logic                 clk,
    input  logic                 global_rst_n,
    input  logic                 ce,
    input  logic                 i_clear,
    input  logic                 i_valid,
    input  logic [BW-1:0]        i_data,
    output logic                 o_ready,
    input  logic                 i_swap,
    output logic [BW*SIZE-1:0]   o_bias,
    output logic                 o_bias_valid,
    output logic [CNT_W-1:0]     o_load_cnt,
    output logic                 o_empty,
    output logic                 o_full
`ifdef BIAS_OVERFLOW_DET_EN
    ,
    output logic                 o_overflow
`endif
);

    logic [1:0][SIZE-1:0][BW-1:0] r_bank;
    logic [1:0]                   r_full;
    logic                         r_wr_bank;
    logic                         r_rd_bank;
    logic [CNT_W-1:0]             r_wr_idx;

    logic                         w_wr_fire;
    logic                         w_wr_last;
    logic                         w_swap_fire;
    logic [1:0]                   w_full_set;
    logic [1:0]                   w_full_clr;

    assign o_ready      = ce & ~r_full[r_wr_bank];
    assign o_bias       = r_bank[r_rd_bank];
    assign o_bias_valid = r_full[r_rd_bank];
    assign o_load_cnt   = r_wr_idx;
    assign o_empty      = (r_full == 2'b00) && (r_wr_idx == '0);
    assign o_full       = (r_full == 2'b11);

    assign w_wr_fire   = i_valid & o_ready;
    assign w_wr_last   = w_wr_fire && (r_wr_idx == CNT_W'(SIZE - 1));
    assign w_swap_fire = ce & i_swap & o_bias_valid;

    // A last write and a swap always hit different banks, so the masks never collide.
    always_comb begin
        w_full_set = 2'b00;
        w_full_clr = 2'b00;
        if (w_wr_last)   w_full_set[r_wr_bank] = 1'b1;
        if (w_swap_fire) w_full_clr[r_rd_bank] = 1'b1;
    end

    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            r_bank    <= '0;
            r_full    <= 2'b00;
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_wr_idx  <= '0;
        end else if (i_clear) begin
            r_bank    <= '0;
            r_full    <= 2'b00;
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_wr_idx  <= '0;
        end else begin
            if (w_wr_fire) begin
                r_bank[r_wr_bank][r_wr_idx] <= i_data;
                if (w_wr_last) begin
                    r_wr_idx  <= '0;
                    r_wr_bank <= ~r_wr_bank;
                end else begin
                    r_wr_idx <= r_wr_idx + 1'b1;
                end
            end
            if (w_swap_fire) r_rd_bank <= ~r_rd_bank;
            r_full <= (r_full | w_full_set) & ~w_full_clr;
        end
    end

`ifdef BIAS_OVERFLOW_DET_EN
    logic r_overflow;

    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n)              r_overflow <= 1'b0;
        else if (i_clear)               r_overflow <= 1'b0;
        else if (ce & i_valid & ~o_ready) r_overflow <= 1'b1;
    end

    assign o_overflow = r_overflow;
`endif

endmodule
